// File: rtl/mul_tg_pkg.sv
// Shared types and constants for the multiplier traffic generator.
// Holds the FSM encoding, the default LFSR seed and the Galois tap mask.
package mul_tg_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRIVE   = 2'd1,
        S_COLLECT = 2'd2,
        S_DONE    = 2'd3
    } tg_state_e;

    // Must be non-zero: an all-zero Galois LFSR never leaves zero.
    localparam logic [63:0] DEFAULT_SEED = 64'hACE1_2468_1357_BDF9;

    // Right-shifting Galois form of x^64 + x^63 + x^61 + x^60 + 1.
    localparam logic [63:0] TAP_MASK = 64'hD800_0000_0000_0000;

endpackage

// File: rtl/mul_tg_if.sv
// Operand and product handshake channels between the traffic generator and the multiplier.
// The master side is the traffic generator; the slave side is the multiplier wrapper.
interface mul_tg_if #(parameter int N = 32);

    logic [N-1:0]   a_o;
    logic [N-1:0]   b_o;
    logic           in_valid_o;
    logic           in_ready_i;
    logic [2*N-1:0] p_i;
    logic           out_valid_i;
    logic           out_ready_o;

    modport master (
        output a_o, b_o, in_valid_o, out_ready_o,
        input  in_ready_i, p_i, out_valid_i
    );

    modport slave (
        input  a_o, b_o, in_valid_o, out_ready_o,
        output in_ready_i, p_i, out_valid_i
    );

endinterface

// File: rtl/mul_tg_lfsr.sv
// W-bit right-shifting Galois LFSR with synchronous load and advance.
// Load has priority over advance; the register reads as zero out of reset.
module mul_tg_lfsr #(
    parameter int           W    = 64,
    parameter logic [W-1:0] TAPS = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         advance,
    output logic [W-1:0] state
);

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= '0;
        end else if (load) begin
            state <= load_val;
        end else if (advance) begin
            state <= state[0] ? ((state >> 1) ^ TAPS) : (state >> 1);
        end
    end

endmodule

// File: rtl/mul_traffic_gen.sv
// Drives LFSR operand pairs into the multiplier and checks each returned product.
// One transaction is outstanding at a time; a watchdog aborts a stalled run.
module mul_traffic_gen
    import mul_tg_pkg::*;
#(
    parameter int N       = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      num_ops,
    input  logic [2*N-1:0]   seed,
    mul_tg_if.master         mif,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [15:0]      pass_count,
    output logic [15:0]      err_count,
    output logic [N-1:0]     first_err_a,
    output logic [N-1:0]     first_err_b,
    output logic [2*N-1:0]   first_err_p
);

    localparam int W    = 2 * N;
    localparam int WD_W = $clog2(TIMEOUT + 1);

    tg_state_e      state_q, state_d;
    logic [15:0]    remaining_q;
    logic [WD_W-1:0] wd_q;
    logic [W-1:0]   lfsr_q;
    logic [W-1:0]   load_val;
    logic [W-1:0]   golden;
    logic           in_xfer, out_xfer, match, wd_fire;
    logic           start_run, lfsr_adv, wd_abort;

    mul_tg_lfsr #(.W(W), .TAPS(W'(TAP_MASK))) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (start_run),
        .load_val (load_val),
        .advance  (lfsr_adv),
        .state    (lfsr_q)
    );

    // Operands come straight from the LFSR register, so they only move when it advances.
    assign mif.a_o         = lfsr_q[N-1:0];
    assign mif.b_o         = lfsr_q[W-1:N];
    assign mif.in_valid_o  = (state_q == S_DRIVE);
    assign mif.out_ready_o = (state_q == S_COLLECT);

    assign busy     = mif.in_valid_o | mif.out_ready_o;
    assign done     = (state_q == S_DONE);
    assign in_xfer  = mif.in_valid_o & mif.in_ready_i;
    assign out_xfer = mif.out_ready_o & mif.out_valid_i;
    assign golden   = W'(mif.a_o) * W'(mif.b_o);
    assign match    = (mif.p_i == golden);
    assign load_val = (seed == '0) ? W'(DEFAULT_SEED) : seed;
    assign wd_fire  = busy && (wd_q == WD_W'(TIMEOUT - 1));

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        start_run = 1'b0;
        lfsr_adv  = 1'b0;
        wd_abort  = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    start_run = 1'b1;
                    state_d   = (num_ops == 16'd0) ? S_DONE : S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (in_xfer) begin
                    state_d = S_COLLECT;
                end else if (wd_fire) begin
                    state_d  = S_DONE;
                    wd_abort = 1'b1;
                end
            end
            S_COLLECT: begin
                if (out_xfer) begin
                    lfsr_adv = 1'b1;
                    state_d  = (remaining_q == 16'd1) ? S_DONE : S_DRIVE;
                end else if (wd_fire) begin
                    state_d  = S_DONE;
                    wd_abort = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            wd_q        <= '0;
            timeout     <= 1'b0;
            pass_count  <= '0;
            err_count   <= '0;
            first_err_a <= '0;
            first_err_b <= '0;
            first_err_p <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= (state_d != state_q || !busy) ? '0 : wd_q + WD_W'(1);

            if (start_run) begin
                remaining_q <= num_ops;
                timeout     <= 1'b0;
                pass_count  <= '0;
                err_count   <= '0;
                first_err_a <= '0;
                first_err_b <= '0;
                first_err_p <= '0;
            end

            if (wd_abort) begin
                timeout <= 1'b1;
            end

            if (out_xfer) begin
                remaining_q <= remaining_q - 16'd1;
                if (match) begin
                    if (pass_count != 16'hFFFF) pass_count <= pass_count + 16'd1;
                end else begin
                    if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                    if (err_count == 16'd0) begin
                        first_err_a <= mif.a_o;
                        first_err_b <= mif.b_o;
                        first_err_p <= mif.p_i;
                    end
                end
            end
        end
    end

endmodule

// File: doc/mul_traffic_gen.md
# mul_traffic_gen

Initiator/collector for the valid/ready multiplier wrapper. It generates pseudo-random unsigned operand pairs from a seeded LFSR and drives them into the multiplier's input handshake. It accepts each product on the multiplier's output handshake, checks it against a golden product, and keeps pass/error counters. It sits at the opposite end of both multiplier channels and is used for self-checking runs of the MBE Dadda multiplier.

## Interface
- N, 32: operand width; product width is 2N.
- TIMEOUT, 1024: maximum cycles spent waiting in DRIVE or COLLECT before the run aborts.
- Clock is clk; reset is rst, synchronous and active-high.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  pulse; begins a run; sampled only in IDLE or DONE.
- num_ops  in  16  number of transactions in the run; sampled with start.
- seed  in  2N  LFSR seed; sampled with start; zero is replaced by DEFAULT_SEED.
- a_o  out  N  operand A to the multiplier.
- b_o  out  N  operand B to the multiplier.
- in_valid_o  out  1  operand pair valid.
- in_ready_i  in  1  multiplier ready to accept operands.
- p_i  in  2N  product from the multiplier.
- out_valid_i  in  1  product valid.
- out_ready_o  out  1  collector ready for the product.
- busy  out  1  run in progress (DRIVE or COLLECT).
- done  out  1  run finished; held until the next start or rst.
- timeout  out  1  the run ended on the watchdog; held with done.
- pass_count  out  16  products that matched; saturating.
- err_count  out  16  products that mismatched; saturating.
- first_err_a, first_err_b  out  N  operands of the first mismatch.
- first_err_p  out  2N  wrong product of the first mismatch.

## Operation
- States: IDLE, DRIVE, COLLECT, DONE.
- IDLE/DONE + start:
  - latch num_ops into `remaining`;
  - load the LFSR with the seed (DEFAULT_SEED if the seed is zero);
  - clear the counters, timeout and first_err_*; clear done;
  - go to DONE if num_ops==0, else DRIVE.
- Operands: a_o = lfsr[N-1:0], b_o = lfsr[2N-1:N]. They are registered and change only when the LFSR advances.
- DRIVE:
  - in_valid_o=1, out_ready_o=0.
  - On in_valid_o && in_ready_i: go to COLLECT.
- COLLECT:
  - in_valid_o=0, out_ready_o=1.
  - a_o/b_o stay stable. The multiplier output is combinational from its inputs, so the operands must not change before the product is taken.
- On out_valid_i && out_ready_o:
  - compare p_i with the golden product a_o*b_o (unsigned, 2N bits);
  - on a match, pass_count+1;
  - on a mismatch, err_count+1, and capture first_err_* if err_count was 0;
  - advance the LFSR and decrement `remaining`;
  - go to DONE if remaining==1, else DRIVE.
- Single outstanding transaction. out_valid_i asserted in DRIVE is ignored.
- Watchdog:
  - a counter clears on every state change and increments in DRIVE/COLLECT;
  - when it reaches TIMEOUT, set timeout=1 and go to DONE with in_valid_o=0 and out_ready_o=0.
- start while busy is ignored.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values:
  - state IDLE;
  - a_o, b_o, first_err_* = 0;
  - in_valid_o, out_ready_o, busy, done, timeout = 0;
  - both counters 0.
- start at edge k: busy=1 and in_valid_o=1 from cycle k+1.
- Input transfer at edge t: in_valid_o=0 and out_ready_o=1 from t+1.
- Output transfer at edge u:
  - counters update at u+1;
  - next operands and in_valid_o=1 at u+1;
  - or done=1 and busy=0 at u+1.
- Minimum transaction: 2 cycles when the responder has zero wait states.
- rst mid-run: all outputs return to reset values on the next edge. The partial transaction is discarded.

## Structure
- Package mul_tg_pkg holds:
  - the state enum;
  - DEFAULT_SEED (2N-bit, non-zero);
  - the LFSR tap mask (64-bit Galois: x^64+x^63+x^61+x^60+1).
- One sub-module, mul_tg_lfsr: parameterised 2N-bit Galois LFSR with load and advance inputs.
- The FSM, checker, counters and watchdog live in mul_traffic_gen.

## Test plan
- Single pass:
  - stimulus: seed=64'h00000003_00000005, num_ops=1, ideal responder;
  - response: a_o=5, b_o=3; pass_count=1, err_count=0; done=1.
- Single mismatch:
  - stimulus: same run, responder returns 16;
  - response: err_count=1; first_err_a=5, first_err_b=3, first_err_p=16.
- Empty run:
  - stimulus: num_ops=0;
  - response: done=1 one cycle after start; in_valid_o never asserted; counters 0.
- Watchdog:
  - stimulus: in_ready_i held low for TIMEOUT cycles;
  - response: timeout=1, done=1, in_valid_o=0; pass_count=0.
- Long run:
  - stimulus: num_ops=1000, responder with random ready/valid delays of 0-7 cycles;
  - response: pass_count=1000; a_o/b_o unchanged from the input transfer to the output transfer (assertion).
- Reset mid-run:
  - stimulus: rst asserted in COLLECT;
  - response: in_valid_o=0, out_ready_o=0, busy=0 and counters 0 on the next cycle; a new start runs normally.
